// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg
//   Shared types and default widths for the flash port arbiter slice.
//   arb_state_t : arbiter transaction phase (IDLE, ISSUE, WAIT_RESP)
//   arb_owner_t : requester that owns the outstanding flash read
package flash_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH      = 24;
    localparam int unsigned DEF_DATA_WIDTH      = 64;
    localparam int unsigned DEF_MAX_DATA_STREAK = 4;
    // Wide enough for the largest legal streak limit (15).
    localparam int unsigned STREAK_WIDTH        = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_DATA
    } arb_owner_t;

endpackage

// File: rtl/flash_arb_priority.sv
// flash_arb_priority
//   Pure combinational grant and streak logic. Loads win unless a fetch is
//   eligible and the data streak has hit MAX_DATA_STREAK.
//   Ports:
//     fetch_req     : fetch unit has a request pending
//     data_req      : load unit has a request pending
//     fetch_blocked : fetch is being flushed this cycle and may not win
//     streak        : consecutive data grants while fetch was waiting
//     grant_fetch   : fetch wins this cycle
//     grant_data    : load wins this cycle
//     streak_next   : streak value to store if a grant is taken
module flash_arb_priority
    import flash_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic                    fetch_req,
    input  logic                    data_req,
    input  logic                    fetch_blocked,
    input  logic [STREAK_WIDTH-1:0] streak,
    output logic                    grant_fetch,
    output logic                    grant_data,
    output logic [STREAK_WIDTH-1:0] streak_next
);

    logic fetch_eligible;
    logic streak_full;

    always_comb begin
        fetch_eligible = fetch_req && !fetch_blocked;
        streak_full    = (streak == STREAK_WIDTH'(MAX_DATA_STREAK));
        // A starving fetch only overrides a load when it can actually win,
        // otherwise the cycle would be wasted with no grant at all.
        grant_data     = data_req && !(fetch_eligible && streak_full);
        grant_fetch    = fetch_eligible && !grant_data;

        streak_next = streak;
        if (grant_fetch) begin
            streak_next = '0;
        end else if (grant_data) begin
            if (!fetch_req) begin
                streak_next = '0;
            end else if (!streak_full) begin
                streak_next = streak + STREAK_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter
//   Shares the single QSPI flash read port between instruction fetch and
//   loads, one transaction outstanding at a time. Fetch flushes cancel an
//   unissued fetch read or drop the stale response of an issued one.
//   Optional macro FLASH_ARB_STATS_EN adds saturating grant/drop counters.
//   Ports:
//     clk, rst                      : clock, async active-high reset
//     fetch_req_* / fetch_flush     : fetch request channel and redirect
//     fetch_resp_*                  : fetch read data (1-cycle pulse)
//     data_req_* / data_resp_*      : load request and response channels
//     flash_req_* / flash_resp_*    : flash controller read port
//     stat_* (FLASH_ARB_STATS_EN)   : fetch grants, data grants, fetch drops
module flash_port_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req_valid,
    output logic                  fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
    input  logic                  fetch_flush,
    output logic                  fetch_resp_valid,
    output logic [DATA_WIDTH-1:0] fetch_resp_data,
    input  logic                  data_req_valid,
    output logic                  data_req_ready,
    input  logic [ADDR_WIDTH-1:0] data_req_addr,
    output logic                  data_resp_valid,
    output logic [DATA_WIDTH-1:0] data_resp_data,
    output logic                  flash_req_valid,
    input  logic                  flash_req_ready,
    output logic [ADDR_WIDTH-1:0] flash_req_addr,
    input  logic                  flash_resp_valid,
    input  logic [DATA_WIDTH-1:0] flash_resp_data
`ifdef FLASH_ARB_STATS_EN
    ,
    output logic [31:0]           stat_fetch_grants,
    output logic [31:0]           stat_data_grants,
    output logic [15:0]           stat_fetch_dropped
`endif
);

    arb_state_t              state_q, state_d;
    arb_owner_t              owner_q, owner_d;
    logic [STREAK_WIDTH-1:0] streak_q, streak_d, streak_next;
    logic                    drop_q, drop_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    fetch_resp_q, data_resp_q;
    logic                    resp_to_fetch, resp_to_data;
    logic                    grant_fetch, grant_data;
    logic                    fetch_flushing;

    flash_arb_priority #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_priority (
        .fetch_req     (fetch_req_valid),
        .data_req      (data_req_valid),
        .fetch_blocked (fetch_flush),
        .streak        (streak_q),
        .grant_fetch   (grant_fetch),
        .grant_data    (grant_data),
        .streak_next   (streak_next)
    );

    assign fetch_flushing = (owner_q == OWNER_FETCH) && fetch_flush;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        streak_d        = streak_q;
        drop_d          = drop_q;
        addr_d          = addr_q;
        fetch_req_ready = 1'b0;
        data_req_ready  = 1'b0;
        flash_req_valid = 1'b0;
        resp_to_fetch   = 1'b0;
        resp_to_data    = 1'b0;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                // Readies are combinational from the requests, so they are
                // gated while reset is held to keep every output at zero.
                if (!rst) begin
                    fetch_req_ready = grant_fetch;
                    data_req_ready  = grant_data;
                    streak_d        = streak_next;
                    if (grant_data) begin
                        owner_d = OWNER_DATA;
                        addr_d  = data_req_addr;
                        state_d = ISSUE;
                    end else if (grant_fetch) begin
                        owner_d = OWNER_FETCH;
                        addr_d  = fetch_req_addr;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // A flush withdraws the request in the same cycle so the
                // controller can never accept a stale fetch.
                if (fetch_flushing) begin
                    state_d = IDLE;
                end else begin
                    flash_req_valid = 1'b1;
                    if (flash_req_ready) begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (flash_resp_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (owner_q == OWNER_DATA) begin
                        resp_to_data = 1'b1;
                    end else if (!drop_q && !fetch_flush) begin
                        resp_to_fetch = 1'b1;
                    end
                end else if (fetch_flushing) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_FETCH;
            streak_q     <= '0;
            drop_q       <= 1'b0;
            addr_q       <= '0;
            resp_data_q  <= '0;
            fetch_resp_q <= 1'b0;
            data_resp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            streak_q     <= streak_d;
            drop_q       <= drop_d;
            addr_q       <= addr_d;
            fetch_resp_q <= resp_to_fetch;
            data_resp_q  <= resp_to_data;
            if (flash_resp_valid && (state_q == WAIT_RESP)) begin
                resp_data_q <= flash_resp_data;
            end
        end
    end

    assign flash_req_addr   = addr_q;
    assign fetch_resp_valid = fetch_resp_q;
    assign data_resp_valid  = data_resp_q;
    assign fetch_resp_data  = resp_data_q;
    assign data_resp_data   = resp_data_q;

`ifdef FLASH_ARB_STATS_EN
    logic fetch_dropped;

    // Cancelled unissued fetches plus responses discarded after a flush.
    assign fetch_dropped = ((state_q == ISSUE) && fetch_flushing)
                        || ((state_q == WAIT_RESP) && flash_resp_valid
                            && (owner_q == OWNER_FETCH) && (drop_q || fetch_flush));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetch_grants  <= '0;
            stat_data_grants   <= '0;
            stat_fetch_dropped <= '0;
        end else begin
            if (fetch_req_ready && (stat_fetch_grants != '1)) begin
                stat_fetch_grants <= stat_fetch_grants + 32'd1;
            end
            if (data_req_ready && (stat_data_grants != '1)) begin
                stat_data_grants <= stat_data_grants + 32'd1;
            end
            if (fetch_dropped && (stat_fetch_dropped != '1)) begin
                stat_fetch_dropped <= stat_fetch_dropped + 16'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_resp_in_wait: assert property (@(posedge clk) disable iff (rst)
        !(flash_resp_valid && (state_q != WAIT_RESP)));
    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(fetch_req_ready && data_req_ready));
`endif

endmodule

// File: tb/tb_flash_port_arbiter.sv
module tb_flash_port_arbiter;

    localparam int AW   = 24;
    localparam int DW   = 64;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req_valid, fetch_req_ready, fetch_flush;
    logic [AW-1:0] fetch_req_addr;
    logic          fetch_resp_valid;
    logic [DW-1:0] fetch_resp_data;
    logic          data_req_valid, data_req_ready;
    logic [AW-1:0] data_req_addr;
    logic          data_resp_valid;
    logic [DW-1:0] data_resp_data;
    logic          flash_req_valid, flash_req_ready;
    logic [AW-1:0] flash_req_addr;
    logic          flash_resp_valid;
    logic [DW-1:0] flash_resp_data;
`ifdef FLASH_ARB_STATS_EN
    logic [31:0]   stat_fetch_grants, stat_data_grants;
    logic [15:0]   stat_fetch_dropped;
`endif

    always #5 clk = ~clk;

    flash_port_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_DATA_STREAK (MAXS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_req_addr   (fetch_req_addr),
        .fetch_flush      (fetch_flush),
        .fetch_resp_valid (fetch_resp_valid),
        .fetch_resp_data  (fetch_resp_data),
        .data_req_valid   (data_req_valid),
        .data_req_ready   (data_req_ready),
        .data_req_addr    (data_req_addr),
        .data_resp_valid  (data_resp_valid),
        .data_resp_data   (data_resp_data),
        .flash_req_valid  (flash_req_valid),
        .flash_req_ready  (flash_req_ready),
        .flash_req_addr   (flash_req_addr),
        .flash_resp_valid (flash_resp_valid),
        .flash_resp_data  (flash_resp_data)
`ifdef FLASH_ARB_STATS_EN
        ,
        .stat_fetch_grants  (stat_fetch_grants),
        .stat_data_grants   (stat_data_grants),
        .stat_fetch_dropped (stat_fetch_dropped)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct {
        bit          is_fetch;
        logic [63:0] data;
        int          due;
    } resp_t;

    resp_t         exp_resp_q[$];
    logic [AW-1:0] exp_flash_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- transaction-level reference model ----------------
    // m_phase: 0 = arbiter free, 1 = request offered to flash, 2 = awaiting data
    int          m_phase = 0;
    bit          m_owner_fetch = 1'b0;
    int          m_streak = 0;
    bit          m_drop = 1'b0;
    int unsigned m_fg = 0, m_dg = 0, m_dropped = 0;

    always @(negedge clk) begin
        bit exp_fr, exp_dr, exp_fv, f_ok;
        exp_fr = 1'b0;
        exp_dr = 1'b0;
        exp_fv = 1'b0;
        f_ok   = 1'b0;
        if (rst) begin
            m_phase = 0; m_streak = 0; m_drop = 1'b0;
            m_fg = 0; m_dg = 0; m_dropped = 0;
            exp_resp_q.delete();
            exp_flash_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    f_ok = fetch_req_valid && !fetch_flush;
                    if (data_req_valid && !(f_ok && m_streak == MAXS)) exp_dr = 1'b1;
                    else if (f_ok) exp_fr = 1'b1;
                    if (exp_dr) begin
                        if (!fetch_req_valid) m_streak = 0;
                        else if (m_streak < MAXS) m_streak = m_streak + 1;
                        m_owner_fetch = 1'b0;
                        exp_flash_q.push_back(data_req_addr);
                        m_dg++;
                        m_phase = 1;
                    end else if (exp_fr) begin
                        m_streak = 0;
                        m_owner_fetch = 1'b1;
                        exp_flash_q.push_back(fetch_req_addr);
                        m_fg++;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (m_owner_fetch && fetch_flush) begin
                        void'(exp_flash_q.pop_back());
                        m_dropped++;
                        m_phase = 0;
                    end else begin
                        exp_fv = 1'b1;
                        if (flash_req_ready) m_phase = 2;
                    end
                end
                default: begin
                    if (flash_resp_valid) begin
                        if (m_owner_fetch && (m_drop || fetch_flush)) m_dropped++;
                        else exp_resp_q.push_back('{is_fetch: m_owner_fetch,
                                                    data: flash_resp_data, due: cyc + 1});
                        m_drop = 1'b0;
                        m_phase = 0;
                    end else if (m_owner_fetch && fetch_flush) begin
                        m_drop = 1'b1;
                    end
                end
            endcase
            check("fetch_req_ready", fetch_req_ready, exp_fr);
            check("data_req_ready", data_req_ready, exp_dr);
            check("flash_req_valid", flash_req_valid, exp_fv);
        end
    end

    // ---------------- monitor ----------------
    int n_fresp = 0, n_dresp = 0;

    always @(negedge clk) begin
        resp_t r;
        #1;
        if (!rst) begin
            if (flash_req_valid && flash_req_ready) begin
                if (exp_flash_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL flash_handshake: got addr %0h, required no handshake", flash_req_addr);
                end else begin
                    check("flash_req_addr", flash_req_addr, exp_flash_q.pop_front());
                end
            end
            if (fetch_resp_valid) n_fresp++;
            if (data_resp_valid)  n_dresp++;
            if (fetch_resp_valid || data_resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp_unexpected: got fetch=%0b data=%0b, required none",
                             fetch_resp_valid, data_resp_valid);
                end else begin
                    r = exp_resp_q.pop_front();
                    check("resp_latency", 64'(cyc), 64'(r.due));
                    check("resp_is_fetch", fetch_resp_valid, r.is_fetch);
                    check("resp_is_data", data_resp_valid, !r.is_fetch);
                    check("resp_data", r.is_fetch ? fetch_resp_data : data_resp_data, r.data);
                end
            end
            while (exp_resp_q.size() > 0 && exp_resp_q[0].due <= cyc) begin
                r = exp_resp_q.pop_front();
                total++; bad++;
                $display("FAIL resp_missing: got no pulse, required data %0h", r.data);
            end
        end
    end

    // ---------------- stimulus: requesters and flash controller ----------------
    bit          f_acc, d_acc, hs, pend;
    int          lat_cfg = -1, lat_cnt = 0, ready_pct = 100;
    bit          data_ovr_en = 1'b0;
    logic [63:0] data_ovr = '0;

    task automatic step();
        @(negedge clk);
        f_acc = fetch_req_ready;
        d_acc = data_req_ready;
        hs    = flash_req_valid && flash_req_ready;
        @(posedge clk);
        #1;
        flash_resp_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (hs) begin
                pend    = 1'b1;
                lat_cnt = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            end
            if (pend) begin
                if (lat_cnt == 0) begin
                    flash_resp_valid = 1'b1;
                    flash_resp_data  = data_ovr_en ? data_ovr : {$urandom, $urandom};
                    pend = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
        end
        flash_req_ready = (int'($urandom_range(1, 100)) <= ready_pct);
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic req_fetch(input logic [AW-1:0] a);
        bit ok = 1'b0;
        fetch_req_valid = 1'b1;
        fetch_req_addr  = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = f_acc;
        end
        fetch_req_valid = 1'b0;
        check("fetch_accept", ok, 1);
    endtask

    task automatic req_data(input logic [AW-1:0] a);
        bit ok = 1'b0;
        data_req_valid = 1'b1;
        data_req_addr  = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = d_acc;
        end
        data_req_valid = 1'b0;
        check("data_accept", ok, 1);
    endtask

    task automatic rand_req();
        if (!fetch_req_valid || f_acc) begin
            fetch_req_valid = ($urandom_range(0, 3) != 0);
            fetch_req_addr  = AW'($urandom) & 24'hFFFFF8;
        end
        if (!data_req_valid || d_acc) begin
            data_req_valid = ($urandom_range(0, 2) == 0);
            data_req_addr  = AW'($urandom);
        end
        fetch_flush = ($urandom_range(0, 11) == 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_fetch_req_ready"}, fetch_req_ready, 0);
        check({tag, "_data_req_ready"}, data_req_ready, 0);
        check({tag, "_flash_req_valid"}, flash_req_valid, 0);
        check({tag, "_flash_req_addr"}, flash_req_addr, 0);
        check({tag, "_fetch_resp_valid"}, fetch_resp_valid, 0);
        check({tag, "_data_resp_valid"}, data_resp_valid, 0);
        check({tag, "_fetch_resp_data"}, fetch_resp_data, 0);
        check({tag, "_data_resp_data"}, data_resp_data, 0);
`ifdef FLASH_ARB_STATS_EN
        check({tag, "_stat_fetch_grants"}, stat_fetch_grants, 0);
        check({tag, "_stat_data_grants"}, stat_data_grants, 0);
        check({tag, "_stat_fetch_dropped"}, stat_fetch_dropped, 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   got_order[10];
        int   ng, n0;
        bit   ok;

        rst = 1'b1;
        fetch_req_valid = 1'b1; fetch_req_addr = 24'h10; fetch_flush = 1'b0;
        data_req_valid  = 1'b1; data_req_addr  = 24'h30;
        flash_req_ready = 1'b1; flash_resp_valid = 1'b0; flash_resp_data = '0;
        pend = 1'b0;

        // Reset state, with requests present to confirm readies stay low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        fetch_req_valid = 1'b0;
        data_req_valid  = 1'b0;
        rst = 1'b0;
        settle(2);

        // Single fetch of 0x20 with a fixed flash latency and known data.
        lat_cfg = 3; data_ovr_en = 1'b1; data_ovr = 64'h11223344AADDEEFF;
        n0 = n_fresp; ng = n_dresp;
        req_fetch(24'h20);
        settle(10);
        check("single_fetch_pulses", 64'(n_fresp - n0), 1);
        check("single_fetch_no_data", 64'(n_dresp - ng), 0);

        // Continuous contention: data wins MAXS times, then fetch.
        lat_cfg = 0; data_ovr_en = 1'b0;
        fetch_req_valid = 1'b1; fetch_req_addr = 24'h1000;
        data_req_valid  = 1'b1; data_req_addr  = 24'h2000;
        ng = 0;
        for (int i = 0; i < 200 && ng < 10; i++) begin
            step();
            if (f_acc) begin got_order[ng] = 1'b1; ng++; fetch_req_addr = fetch_req_addr + 24'd8; end
            else if (d_acc) begin got_order[ng] = 1'b0; ng++; data_req_addr = data_req_addr + 24'd8; end
        end
        fetch_req_valid = 1'b0; data_req_valid = 1'b0;
        check("grant_count", 64'(ng), 10);
        for (int k = 0; k < 10; k++) check($sformatf("grant_order_%0d", k), got_order[k], (k % 5) == 4);
        settle(10);

        // Flush while the fetch is stuck in ISSUE; the pending load then wins.
        ready_pct = 0; flash_req_ready = 1'b0; lat_cfg = -1;
        req_fetch(24'h40);
        fetch_flush = 1'b1;
        data_req_valid = 1'b1; data_req_addr = 24'h100;
        step();
        fetch_flush = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5 && !ok; i++) begin
            step();
            ok = d_acc;
        end
        check("data_grant_after_cancel", ok, 1);
        data_req_valid = 1'b0;
        ready_pct = 100;
        settle(10);

        // Flush in the same cycle as the flash response drops it.
        lat_cfg = 1; data_ovr_en = 1'b1; data_ovr = 64'h99331144BBCC00EE;
        n0 = n_fresp;
        req_fetch(24'h60);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = flash_resp_valid;
        end
        check("flush_resp_seen", ok, 1);
        fetch_flush = 1'b1;
        step();
        fetch_flush = 1'b0;
        settle(5);
        check("flushed_resp_pulses", 64'(n_fresp - n0), 0);
        data_ovr_en = 1'b0;
        req_fetch(24'h24);
        settle(10);
        check("fetch_after_flush_pulses", 64'(n_fresp - n0), 1);

        // Reset in the middle of a data read; a late response must be ignored.
        lat_cfg = 6;
        req_data(24'h200);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = hs;
        end
        check("reset_case_handshake", ok, 1);
        #3 rst = 1'b1;
        #1 check_outputs_zero("midrst");
        @(posedge clk); #1;
        flash_resp_valid = 1'b1; flash_resp_data = 64'hDEADBEEFCAFEF00D;
        @(posedge clk); #1;
        flash_resp_valid = 1'b0;
        pend = 1'b0;
        rst = 1'b0;
        n0 = n_dresp;
        settle(10);
        check("late_resp_after_reset", 64'(n_dresp - n0), 0);

        // Randomised traffic.
        lat_cfg = -1; ready_pct = 60;
        repeat (3000) begin
            step();
            rand_req();
        end
        fetch_req_valid = 1'b0; data_req_valid = 1'b0; fetch_flush = 1'b0;
        ready_pct = 100;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = (m_phase == 0) && (exp_resp_q.size() == 0) && (exp_flash_q.size() == 0) && !pend;
        end
        settle(3);
        check("drained", ok, 1);

`ifdef FLASH_ARB_STATS_EN
        check("stat_fetch_grants", stat_fetch_grants, 64'(m_fg));
        check("stat_data_grants", stat_data_grants, 64'(m_dg));
        check("stat_fetch_dropped", stat_fetch_dropped, 64'(m_dropped));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
